// File: rtl/spi_sclk_if.sv
// Control/strobe bundle between the SPI register block (master) and the SCLK engine (slave).
interface spi_sclk_if #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int DIV_W  = 12,
  parameter int BITS_W = 4
);
  logic              start;
  logic              abort;
  logic              halt;
  logic              cpol;
  logic              cpha;
  logic [SPPR_W-1:0] sppr;
  logic [SPR_W-1:0]  spr;
  logic [BITS_W-1:0] frame_len;
  logic              sclk;
  logic              sample_pulse;
  logic              shift_pulse;
  logic              pre_sample;
  logic              pre_shift;
  logic              busy;
  logic              done;
  logic [DIV_W-1:0]  baudratedivisor;

  modport master (
    output start, abort, halt, cpol, cpha, sppr, spr, frame_len,
    input  sclk, sample_pulse, shift_pulse, pre_sample, pre_shift, busy, done,
           baudratedivisor
  );

  modport slave (
    input  start, abort, halt, cpol, cpha, sppr, spr, frame_len,
    output sclk, sample_pulse, shift_pulse, pre_sample, pre_shift, busy, done,
           baudratedivisor
  );
endinterface

// File: rtl/spi_sclk_engine.sv
// SPI master SCLK generator: one framed transfer of frame_len+1 bits in any CPOL/CPHA
// mode, with sample/shift strobes, early strobes, halt freeze and abort.
module spi_sclk_engine #(
  parameter int SPPR_W = 3,
  parameter int SPR_W  = 3,
  parameter int DIV_W  = 12,
  parameter int BITS_W = 4
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  spi_sclk_if.slave   bus
);
  localparam int EW = BITS_W + 2;

  typedef enum logic [1:0] {IDLE, RUN, TRAIL} state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] cnt, cnt_n;
  logic [DIV_W-1:0] div_l, div_n;
  logic [EW-1:0]    edge_cnt, edge_n;
  logic [EW-1:0]    two_n_l, two_n_n;
  logic             cpol_l, cpol_n;
  logic             cpha_l, cpha_n;
  logic             sclk_r, sclk_n;
  logic             sample_r, sample_n;
  logic             shift_r, shift_n;
  logic             done_r, done_n;

  logic [SPR_W:0]   shamt;
  logic [DIV_W-1:0] div_live;
  logic [EW-1:0]    k;
  logic             wrap;
  logic             pre_run;

  function automatic logic is_sample(input logic ph, input logic [EW-1:0] e);
    return ph ? ~e[0] : e[0];
  endfunction

  // The last even edge in CPHA=0 returns sclk to idle and carries no shift.
  function automatic logic is_shift(input logic ph, input logic [EW-1:0] e,
                                    input logic [EW-1:0] last);
    return ph ? e[0] : (~e[0] && (e != last));
  endfunction

  assign shamt    = {1'b0, bus.spr} + {{SPR_W{1'b0}}, 1'b1};
  assign div_live = (DIV_W'(bus.sppr) + DIV_W'(1)) << shamt;
  assign k        = edge_cnt + EW'(1);
  assign wrap     = (cnt == div_l - DIV_W'(1));
  assign pre_run  = (state == RUN) && !bus.halt && !bus.abort && wrap;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      cnt      <= '0;
      div_l    <= '0;
      edge_cnt <= '0;
      two_n_l  <= '0;
      cpol_l   <= 1'b0;
      cpha_l   <= 1'b0;
      sclk_r   <= 1'b0;
      sample_r <= 1'b0;
      shift_r  <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_l    <= div_n;
      edge_cnt <= edge_n;
      two_n_l  <= two_n_n;
      cpol_l   <= cpol_n;
      cpha_l   <= cpha_n;
      sclk_r   <= sclk_n;
      sample_r <= sample_n;
      shift_r  <= shift_n;
      done_r   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    div_n    = div_l;
    edge_n   = edge_cnt;
    two_n_n  = two_n_l;
    cpol_n   = cpol_l;
    cpha_n   = cpha_l;
    sclk_n   = sclk_r;
    sample_n = 1'b0;
    shift_n  = 1'b0;
    done_n   = 1'b0;
    if (bus.abort) begin
      state_n = IDLE;
      cnt_n   = '0;
      edge_n  = '0;
      sclk_n  = bus.cpol;
    end else begin
      unique case (state)
        IDLE: begin
          sclk_n = bus.cpol;
          cnt_n  = '0;
          edge_n = '0;
          if (bus.start) begin
            state_n = RUN;
            cpol_n  = bus.cpol;
            cpha_n  = bus.cpha;
            div_n   = div_live;
            two_n_n = (EW'(bus.frame_len) + EW'(1)) << 1;
          end
        end
        RUN: begin
          if (!bus.halt) begin
            if (wrap) begin
              cnt_n    = '0;
              edge_n   = k;
              sclk_n   = ~sclk_r;
              sample_n = is_sample(cpha_l, k);
              shift_n  = is_shift(cpha_l, k, two_n_l);
              if (k == two_n_l) state_n = TRAIL;
            end else begin
              cnt_n = cnt + DIV_W'(1);
            end
          end
        end
        TRAIL: begin
          if (!bus.halt) begin
            if (wrap) begin
              state_n = IDLE;
              done_n  = 1'b1;
              cnt_n   = '0;
              edge_n  = '0;
              sclk_n  = cpol_l;
            end else begin
              cnt_n = cnt + DIV_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.sclk            = sclk_r;
  assign bus.sample_pulse    = sample_r;
  assign bus.shift_pulse     = shift_r;
  assign bus.pre_sample      = pre_run && is_sample(cpha_l, k);
  assign bus.pre_shift       = pre_run && is_shift(cpha_l, k, two_n_l);
  assign bus.busy            = (state != IDLE);
  assign bus.done            = done_r;
  assign bus.baudratedivisor = div_live;
endmodule

// File: tb/tb_spi_sclk_engine.sv
// Directed bench for spi_sclk_engine: table of frame configurations plus halt, abort,
// mid-frame disturbance, back-to-back and asynchronous reset sequences.
module tb_spi_sclk_engine;
  localparam int SPPR_W = 3, SPR_W = 3, DIV_W = 12, BITS_W = 4;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  spi_sclk_if #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .DIV_W(DIV_W), .BITS_W(BITS_W)) bus ();

  spi_sclk_engine #(.SPPR_W(SPPR_W), .SPR_W(SPR_W), .DIV_W(DIV_W), .BITS_W(BITS_W)) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .bus    (bus.slave)
  );

  typedef struct {
    bit cpol;
    bit cpha;
    int sppr;
    int spr;
    int flen;
    int d;
    int done_off;
    int ns;
    int nh;
  } vec_t;

  vec_t tbl[6];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  int   edge_q[$], samp_q[$], shft_q[$], pres_q[$], preh_q[$], done_q[$];
  logic prev_sclk = 1'b0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(negedge PCLK) begin
    if (bus.busy && (bus.sclk !== prev_sclk)) edge_q.push_back(cyc);
    prev_sclk = bus.sclk;
    if (bus.sample_pulse) samp_q.push_back(cyc);
    if (bus.shift_pulse)  shft_q.push_back(cyc);
    if (bus.pre_sample)   pres_q.push_back(cyc);
    if (bus.pre_shift)    preh_q.push_back(cyc);
    if (bus.done)         done_q.push_back(cyc);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge PCLK);
    #1;
  endtask

  task automatic clr();
    edge_q.delete(); samp_q.delete(); shft_q.delete();
    pres_q.delete(); preh_q.delete(); done_q.delete();
  endtask

  task automatic set_cfg(input vec_t v);
    bus.cpol      = v.cpol;
    bus.cpha      = v.cpha;
    bus.sppr      = SPPR_W'(v.sppr);
    bus.spr       = SPR_W'(v.spr);
    bus.frame_len = BITS_W'(v.flen);
    tick();
    tick();
  endtask

  task automatic start_frame(output int t);
    clr();
    bus.start = 1'b1;
    t = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit b2b, output int dc);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    chk({tag, " done_seen"}, bus.done, 1);
    dc = cyc;
    if (b2b) bus.start = 1'b1;
  endtask

  task automatic wait_edges(input string tag, input int cnt, input int budget);
    int n = 0;
    while (edge_q.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk({tag, " edges_reached"}, edge_q.size() >= cnt, 1);
  endtask

  task automatic check_frame(input string tag, input vec_t v, input int t,
                             input int hc, input int hl);
    int n2;
    int es[$], ss[$], hs[$];
    int bad;
    n2 = 2 * (v.flen + 1);
    for (int k = 1; k <= n2; k++) begin
      int tt;
      tt = t + 1 + k * v.d;
      if (hl > 0 && tt > hc) tt += hl;
      es.push_back(tt);
      if (v.cpha ? (k % 2 == 0) : (k % 2 == 1)) ss.push_back(tt);
      if (v.cpha ? (k % 2 == 1) : (k % 2 == 0 && k != n2)) hs.push_back(tt);
    end
    chk({tag, " edge_count"}, edge_q.size(), n2);
    bad = 0;
    foreach (es[i]) if (i >= edge_q.size() || edge_q[i] != es[i]) bad++;
    chk({tag, " edge_time_errs"}, bad, 0);
    if (edge_q.size() > 0) chk({tag, " first_edge"}, edge_q[0], t + 1 + v.d);
    chk({tag, " sample_count"}, samp_q.size(), v.ns);
    bad = 0;
    foreach (ss[i]) if (i >= samp_q.size() || samp_q[i] != ss[i]) bad++;
    chk({tag, " sample_time_errs"}, bad, 0);
    chk({tag, " shift_count"}, shft_q.size(), v.nh);
    bad = 0;
    foreach (hs[i]) if (i >= shft_q.size() || shft_q[i] != hs[i]) bad++;
    chk({tag, " shift_time_errs"}, bad, 0);
    bad = 0;
    if (pres_q.size() != samp_q.size()) bad++;
    else foreach (pres_q[i]) if (pres_q[i] + 1 != samp_q[i]) bad++;
    chk({tag, " pre_sample_align_errs"}, bad, 0);
    bad = 0;
    if (preh_q.size() != shft_q.size()) bad++;
    else foreach (preh_q[i]) if (preh_q[i] + 1 != shft_q[i]) bad++;
    chk({tag, " pre_shift_align_errs"}, bad, 0);
    chk({tag, " done_count"}, done_q.size(), 1);
    if (done_q.size() > 0) chk({tag, " done_cycle"}, done_q[0], t + v.done_off + hl);
  endtask

  initial begin
    int t, t2, dc;
    vec_t v;
    //            cpol cpha sppr spr flen    D  done  ns  nh
    tbl[0] = '{1'b0, 1'b0,  0,  0,   7,    2,   35,  8,  7};
    tbl[1] = '{1'b1, 1'b1,  2,  1,   3,   12,  109,  4,  4};
    tbl[2] = '{1'b0, 1'b1,  1,  0,   0,    4,   13,  1,  1};
    tbl[3] = '{1'b1, 1'b0,  0,  1,   2,    4,   29,  3,  2};
    tbl[4] = '{1'b0, 1'b0,  7,  7,   0, 2048, 6145,  1,  0};
    tbl[5] = '{1'b1, 1'b1,  3,  0,  15,    8,  265, 16, 16};

    bus.start = 0; bus.abort = 0; bus.halt = 0; bus.cpol = 0; bus.cpha = 0;
    bus.sppr = '0; bus.spr = '0; bus.frame_len = '0;

    // Reset values, then sclk follows cpol after the first clock.
    tick();
    bus.cpol = 1'b1;
    tick();
    chk("reset sclk", bus.sclk, 0);
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset sample", bus.sample_pulse, 0);
    PRESETn = 1'b1;
    tick();
    chk("idle sclk tracks cpol", bus.sclk, 1);
    bus.cpol = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      set_cfg(tbl[i]);
      chk({tag, " idle_sclk"}, bus.sclk, tbl[i].cpol);
      chk({tag, " divisor"}, bus.baudratedivisor, tbl[i].d);
      start_frame(t);
      chk({tag, " busy_after_start"}, bus.busy, 1);
      wait_done(tag, tbl[i].done_off + 50, 1'b0, dc);
      check_frame(tag, tbl[i], t, 0, 0);
      chk({tag, " busy_at_done"}, bus.busy, 0);
      chk({tag, " sclk_at_done"}, bus.sclk, tbl[i].cpol);
    end

    // Halt for 5 cycles right after edge 5.
    set_cfg(tbl[0]);
    start_frame(t);
    wait_edges("halt", 5, 100);
    t2 = cyc;
    bus.halt = 1'b1;
    repeat (5) tick();
    bus.halt = 1'b0;
    wait_done("halt", 100, 1'b0, dc);
    check_frame("halt", tbl[0], t, t2, 5);

    // Abort the cycle after edge 3, then restart immediately.
    set_cfg(tbl[0]);
    start_frame(t);
    wait_edges("abort", 3, 100);
    tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort sclk", bus.sclk, 0);
    chk("abort strobes", {bus.sample_pulse, bus.shift_pulse}, 0);
    chk("abort edge_count", edge_q.size(), 3);
    chk("abort no_done", done_q.size(), 0);
    start_frame(t);
    chk("restart busy", bus.busy, 1);
    wait_done("restart", 100, 1'b0, dc);
    check_frame("restart", tbl[0], t, 0, 0);

    // Mid-frame input disturbance, then back-to-back start on the done cycle.
    set_cfg(tbl[1]);
    start_frame(t);
    repeat (20) tick();
    bus.cpha = 1'b0;
    bus.sppr = 3'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("disturb live divisor", bus.baudratedivisor, 24);
    repeat (10) tick();
    bus.cpha = 1'b1;
    bus.sppr = 3'd2;
    wait_done("disturb", 200, 1'b1, dc);
    check_frame("disturb", tbl[1], t, 0, 0);
    t2 = dc;
    clr();
    tick();
    bus.start = 1'b0;
    chk("b2b busy", bus.busy, 1);
    wait_done("b2b", 200, 1'b0, dc);
    check_frame("b2b", tbl[1], t2, 0, 0);

    // Asynchronous reset in the trailing phase of a slow idle-high frame.
    v = tbl[4];
    v.cpol = 1'b1;
    set_cfg(v);
    start_frame(t);
    repeat (5000) tick();
    chk("slow edge_count", edge_q.size(), 2);
    if (edge_q.size() == 2) chk("slow edge_spacing", edge_q[1] - edge_q[0], 2048);
    chk("slow sclk_before_reset", bus.sclk, 1);
    @(posedge PCLK);
    #3;
    PRESETn = 1'b0;
    #1;
    chk("async reset sclk", bus.sclk, 0);
    chk("async reset busy", bus.busy, 0);
    chk("async reset strobes",
        {bus.sample_pulse, bus.shift_pulse, bus.pre_sample, bus.pre_shift, bus.done}, 0);
    tick();
    PRESETn = 1'b1;
    tick();
    chk("post reset sclk", bus.sclk, 1);
    chk("post reset busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
